// File: rtl/jtag_shift_engine.sv
// jtag_shift_engine
//   Bit-serial JTAG shifter sitting directly behind the TCK generator.
//   A command carries up to DATA_W TMS/TDI bit pairs (LSB first). Each bit is
//   driven on a jtag_wr_en strobe (TCK falling edge) and the matching TDO is
//   captured on the following jtag_rd_en strobe (TCK rising edge). The
//   captured word is returned through a valid/ready response port.
//
// Ports
//   ref_clk     single clock, shared with the TCK generator
//   rst         synchronous, active-high reset
//   jtag_rd_en  strobe one ref_clk before each TCK rising edge (TDO sample)
//   jtag_wr_en  strobe one ref_clk before each TCK falling edge (TMS/TDI update)
//   cmd_valid   command present
//   cmd_ready   engine accepts a command
//   cmd_len     bits to shift; 0 legal; values above DATA_W clamp to DATA_W
//   cmd_tms     TMS bits, LSB shifted first
//   cmd_tdi     TDI bits, LSB shifted first
//   rsp_valid   captured word available
//   rsp_ready   consumer accepts the response
//   rsp_tdo     captured TDO; bit i = TDO for shifted bit i, upper bits 0
//   busy        high whenever the engine is not idle
//   tms, tdi    JTAG outputs, hold their last driven value
//   tdo         JTAG input, sampled directly (stable half a TCK before rise)

module jtag_shift_engine #(
   parameter int DATA_W = 32,
   parameter int LEN_W  = 6
) (
   input  logic              ref_clk,
   input  logic              rst,
   input  logic              jtag_rd_en,
   input  logic              jtag_wr_en,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic [DATA_W-1:0] cmd_tms,
   input  logic [DATA_W-1:0] cmd_tdi,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_tdo,
   output logic              busy,
   output logic              tms,
   output logic              tdi,
   input  logic              tdo
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRIVE,
      S_SAMPLE,
      S_RESP
   } state_t;

   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DATA_W);

   state_t            state;
   logic [DATA_W-1:0] tms_sr;
   logic [DATA_W-1:0] tdi_sr;
   logic [DATA_W-1:0] cap_mask;
   logic [LEN_W-1:0]  idx;
   logic [LEN_W-1:0]  eff_len;
   logic [LEN_W-1:0]  clamp_len;
   logic [LEN_W-1:0]  idx_next;

   assign clamp_len = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;
   assign idx_next  = idx + LEN_W'(1);
   assign busy      = (state != S_IDLE);

   // Bit selection uses right-shifting word registers and a one-hot capture
   // mask that walks left, rather than indexing by idx; idx only tracks the
   // count against eff_len. rsp_tdo is cleared on accept, so OR-ing in a 1
   // at the mask position is the same as writing rsp_tdo[idx] <= tdo.
   always_ff @(posedge ref_clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cmd_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_tdo   <= '0;
         tms       <= 1'b1;
         tdi       <= 1'b0;
         tms_sr    <= '0;
         tdi_sr    <= '0;
         cap_mask  <= '0;
         idx       <= '0;
         eff_len   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  tms_sr    <= cmd_tms;
                  tdi_sr    <= cmd_tdi;
                  eff_len   <= clamp_len;
                  idx       <= '0;
                  rsp_tdo   <= '0;
                  cap_mask  <= DATA_W'(1);
                  if (clamp_len == '0) begin
                     rsp_valid <= 1'b1;
                     state     <= S_RESP;
                  end else begin
                     state <= S_DRIVE;
                  end
               end else begin
                  cmd_ready <= 1'b1;
               end
            end

            // Read strobes here are ignored: every bit starts on a falling edge.
            S_DRIVE: begin
               if (jtag_wr_en) begin
                  tms    <= tms_sr[0];
                  tdi    <= tdi_sr[0];
                  tms_sr <= tms_sr >> 1;
                  tdi_sr <= tdi_sr >> 1;
                  state  <= S_SAMPLE;
               end
            end

            S_SAMPLE: begin
               if (jtag_rd_en) begin
                  if (tdo) begin
                     rsp_tdo <= rsp_tdo | cap_mask;
                  end
                  cap_mask <= cap_mask << 1;
                  idx      <= idx_next;
                  if (idx_next == eff_len) begin
                     rsp_valid <= 1'b1;
                     state     <= S_RESP;
                  end else begin
                     state <= S_DRIVE;
                  end
               end
            end

            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jtag_shift_engine.sv
// tb_jtag_shift_engine
//   Scoreboard bench for jtag_shift_engine. A TCK strobe generator drives
//   jtag_wr_en/jtag_rd_en with programmable phase lengths; tdo is produced by
//   a simple target model (loopback, inverted loopback, tied 1, tied 0).
//   Commands push their expected response into a queue; a monitor pops it on
//   every response handshake and also compares the TMS/TDI bit stream seen on
//   the wire at each TCK rising edge against the command words.

module tb_jtag_shift_engine;

   localparam int DW = 32;
   localparam int LW = 6;

   logic          ref_clk = 1'b0;
   logic          rst;
   logic          jtag_rd_en;
   logic          jtag_wr_en;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [LW-1:0] cmd_len;
   logic [DW-1:0] cmd_tms;
   logic [DW-1:0] cmd_tdi;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_tdo;
   logic          busy;
   logic          tms;
   logic          tdi;
   logic          tdo;

   typedef struct {
      logic [DW-1:0] tdo;
      logic [DW-1:0] tms;
      logic [DW-1:0] tdi;
      logic [DW-1:0] mask;
      int            n;
   } exp_t;

   exp_t exp_q[$];
   bit   obs_tms[$];
   bit   obs_tdi[$];

   int checks      = 0;
   int errors      = 0;
   int total_bits  = 0;
   int resp_count  = 0;
   int accept_resp = 0;
   int lo_ph       = 2;
   int hi_ph       = 2;
   int tdo_mode    = 0;

   always #5 ref_clk = ~ref_clk;

   // Target model: 0 loopback, 1 inverted loopback, 2 tied high, 3 tied low.
   assign tdo = (tdo_mode == 0) ? tdi :
                (tdo_mode == 1) ? ~tdi :
                (tdo_mode == 2);

   jtag_shift_engine #(.DATA_W(DW), .LEN_W(LW)) dut (
      .ref_clk    (ref_clk),
      .rst        (rst),
      .jtag_rd_en (jtag_rd_en),
      .jtag_wr_en (jtag_wr_en),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_len    (cmd_len),
      .cmd_tms    (cmd_tms),
      .cmd_tdi    (cmd_tdi),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_tdo    (rsp_tdo),
      .busy       (busy),
      .tms        (tms),
      .tdi        (tdi),
      .tdo        (tdo)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: actual=timeout required=event", name);
   endtask

   // TCK generator: falling-edge strobe at phase 0, rising-edge strobe after lo_ph cycles.
   initial begin
      int ph;
      ph = 0;
      jtag_wr_en = 1'b0;
      jtag_rd_en = 1'b0;
      forever begin
         @(negedge ref_clk);
         jtag_wr_en = (ph == 0);
         jtag_rd_en = (ph == lo_ph);
         ph = (ph + 1 >= lo_ph + hi_ph) ? 0 : ph + 1;
      end
   end

   // Monitor: a bit is shifted when a TCK rise follows a TCK fall while the
   // engine is active; the wire values at that rise are the shifted bit.
   initial begin
      exp_t          e;
      logic [DW-1:0] ot;
      logic [DW-1:0] od;
      bit            fell;
      fell = 1'b0;
      forever begin
         @(negedge ref_clk);
         #1;
         if (rst) begin
            obs_tms.delete();
            obs_tdi.delete();
            fell = 1'b0;
         end else begin
            if (jtag_wr_en && busy && !rsp_valid) fell = 1'b1;
            if (jtag_rd_en && busy && !rsp_valid && fell) begin
               obs_tms.push_back(tms);
               obs_tdi.push_back(tdi);
               total_bits++;
               fell = 1'b0;
            end
            if (rsp_valid && rsp_ready) begin
               resp_count++;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_rsp: actual=%0h required=no response", rsp_tdo);
               end else begin
                  e  = exp_q.pop_front();
                  ot = '0;
                  od = '0;
                  for (int i = 0; i < obs_tms.size() && i < DW; i++) begin
                     ot[i] = obs_tms[i];
                     od[i] = obs_tdi[i];
                  end
                  chk("rsp_tdo", 64'(rsp_tdo), 64'(e.tdo));
                  chk("bit_count", 64'(obs_tms.size()), 64'(e.n));
                  chk("tms_seq", 64'(ot), 64'(e.tms & e.mask));
                  chk("tdi_seq", 64'(od), 64'(e.tdi & e.mask));
               end
               obs_tms.delete();
               obs_tdi.delete();
            end
         end
      end
   end

   // Issue one command; returns at the negedge after the accepting edge.
   task automatic send(input int len, input logic [DW-1:0] tw, input logic [DW-1:0] dw, input bit hold);
      exp_t e;
      int   n;
      e.n    = (len > DW) ? DW : len;
      e.mask = (e.n == DW) ? '1 : ((DW'(1) << e.n) - DW'(1));
      e.tms  = tw;
      e.tdi  = dw;
      case (tdo_mode)
         0:       e.tdo = dw & e.mask;
         1:       e.tdo = ~dw & e.mask;
         2:       e.tdo = e.mask;
         default: e.tdo = '0;
      endcase
      exp_q.push_back(e);
      cmd_len   = LW'(len);
      cmd_tms   = tw;
      cmd_tdi   = dw;
      cmd_valid = 1'b1;
      n = 0;
      while (!cmd_ready && n < 3000) begin
         @(negedge ref_clk);
         n++;
      end
      if (!cmd_ready) timeout_fail("cmd_accept");
      accept_resp = resp_count;
      @(negedge ref_clk);
      if (!hold) cmd_valid = 1'b0;
   endtask

   task automatic wait_drain(input bit rand_stall);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 5000) begin
         @(negedge ref_clk);
         if (rand_stall) rsp_ready = ($urandom_range(0, 3) != 0);
         n++;
      end
      if (exp_q.size() != 0) begin
         timeout_fail("rsp_drain");
         exp_q.delete();
      end
      rsp_ready = 1'b1;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [DW-1:0] snap;
      logic          st;
      logic          sd;
      int            n;
      int            viol;
      int            b0;
      int            r0;

      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_len   = '0;
      cmd_tms   = '0;
      cmd_tdi   = '0;
      rsp_ready = 1'b1;
      repeat (3) @(negedge ref_clk);
      chk("rst_tms", 64'(tms), 64'(1));
      chk("rst_tdi", 64'(tdi), 64'(0));
      chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
      chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("rst_rsp_tdo", 64'(rsp_tdo), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      rst = 1'b0;
      @(negedge ref_clk);
      chk("cmd_ready_after_rst", 64'(cmd_ready), 64'(1));

      // Loopback of 0xA5 with TMS held low.
      tdo_mode = 0;
      send(8, 32'h0, 32'hA5, 1'b0);
      wait_drain(1'b0);

      // TAP reset walk: five TMS=1 then one TMS=0.
      tdo_mode = 3;
      send(6, 32'h1F, 32'h0, 1'b0);
      wait_drain(1'b0);

      // Zero length: immediate response, wire untouched.
      st = tms;
      sd = tdi;
      send(0, $urandom(), $urandom(), 1'b0);
      n = 0;
      while (!rsp_valid && n < 2) begin
         @(negedge ref_clk);
         n++;
      end
      chk("zero_len_rsp_valid", 64'(rsp_valid), 64'(1));
      wait_drain(1'b0);
      chk("zero_len_tms", 64'(tms), 64'(st));
      chk("zero_len_tdi", 64'(tdi), 64'(sd));

      // Clamp: 40 requested, 32 shifted.
      tdo_mode = 1;
      send(40, $urandom(), $urandom(), 1'b0);
      wait_drain(1'b0);

      // Backpressure for 50 cycles.
      rsp_ready = 1'b0;
      tdo_mode  = 2;
      send(12, $urandom(), $urandom(), 1'b0);
      n = 0;
      while (!rsp_valid && n < 500) begin
         @(negedge ref_clk);
         n++;
      end
      if (!rsp_valid) timeout_fail("stall_rsp_valid");
      snap = rsp_tdo;
      st   = tms;
      sd   = tdi;
      viol = 0;
      repeat (50) begin
         @(negedge ref_clk);
         if (rsp_valid !== 1'b1 || rsp_tdo !== snap || cmd_ready !== 1'b0 ||
             tms !== st || tdi !== sd) viol++;
      end
      chk("stall_stable", 64'(viol), 64'(0));
      rsp_ready = 1'b1;
      @(negedge ref_clk);
      chk("stall_rsp_valid_drop", 64'(rsp_valid), 64'(0));
      @(negedge ref_clk);
      chk("stall_cmd_ready_return", 64'(cmd_ready), 64'(1));

      // Back-to-back 32-bit commands, cmd_valid held between them.
      tdo_mode = 2;
      b0 = total_bits;
      r0 = resp_count;
      send(32, $urandom(), $urandom(), 1'b1);
      send(32, $urandom(), $urandom(), 1'b0);
      chk("b2b_second_after_first_rsp", 64'(accept_resp), 64'(r0 + 1));
      wait_drain(1'b0);
      chk("b2b_bits", 64'(total_bits - b0), 64'(64));

      // Reset around bit 10 of a 32-bit command, then a short command.
      tdo_mode = 0;
      b0 = total_bits;
      send(32, $urandom(), $urandom(), 1'b0);
      n = 0;
      while (total_bits - b0 < 10 && n < 2000) begin
         @(negedge ref_clk);
         n++;
      end
      if (total_bits - b0 < 10) timeout_fail("midshift_bits");
      rst = 1'b1;
      exp_q.delete();
      @(negedge ref_clk);
      rst = 1'b0;
      chk("midrst_busy", 64'(busy), 64'(0));
      chk("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("midrst_tms", 64'(tms), 64'(1));
      send(4, 32'h5, 32'hA, 1'b0);
      wait_drain(1'b0);

      // Randomized commands, phase lengths, target behaviour and stalls.
      repeat (30) begin
         lo_ph    = $urandom_range(1, 3);
         hi_ph    = $urandom_range(1, 3);
         tdo_mode = $urandom_range(0, 3);
         send($urandom_range(0, 40), $urandom(), $urandom(), 1'b0);
         wait_drain(1'b1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
